// File: rtl/dds_compiler.sv
// Single-channel DDS: 16-bit phase accumulator feeding a quarter-wave sine ROM.
// Five register stages; a sample appears four edges after its accept edge.
module dds_compiler (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_phase_tvalid,
   input  logic [15:0] s_axis_phase_tdata,
   output logic        m_axis_data_tvalid,
   output logic [15:0] m_axis_data_tdata
);

   // pi in unsigned Q4.60
   localparam logic [63:0] PI_Q60 = 64'h3243F6A8885A308D;

   // round(32767*sin(2*pi*k/1024)), fixed-point Taylor series at elaboration
   function automatic logic [15:0] sin_q15(input int k);
      logic [127:0] x;
      logic [127:0] x2;
      logic [127:0] term;
      logic [127:0] sum;
      logic [127:0] v;
      x    = (128'(PI_Q60) * 128'(unsigned'(k))) >> 9;
      x2   = (x * x) >> 60;
      term = x;
      sum  = x;
      for (int n = 1; n <= 14; n++) begin
         term = ((term * x2) >> 60) / 128'(unsigned'((2 * n) * (2 * n + 1)));
         if (n[0]) sum = sum - term;
         else      sum = sum + term;
      end
      v = sum * 128'd32767 + (128'd1 << 59);
      return v[75:60];
   endfunction

   logic [15:0] rom [257];

   for (genvar k = 0; k < 257; k++) begin : g_rom
      localparam logic [15:0] V = sin_q15(k);
      assign rom[k] = V;
   end

   logic        accept;
   logic [15:0] acc_q, acc_d;
   logic [9:0]  p_q, p_d;
   logic        v1_q;
   logic [8:0]  idx2_q, idx2_d;
   logic        neg2_q;
   logic        v2_q;
   logic [15:0] mag3_q, mag3_d;
   logic        neg3_q;
   logic        v3_q;
   logic [15:0] s4_q, s4_d;
   logic        v4_q;
   logic [15:0] dat_q, dat_d;
   logic        vo_q;

   always_comb begin
      accept = !aresetn && s_axis_phase_tvalid;
      acc_d  = acc_q;
      p_d    = p_q;
      if (accept) begin
         acc_d = acc_q + s_axis_phase_tdata;
         p_d   = acc_q[15:6];
      end
      idx2_d = {1'b0, p_q[7:0]};
      if (p_q[8]) idx2_d = 9'd256 - {1'b0, p_q[7:0]};
      mag3_d = rom[idx2_q];
      s4_d   = neg3_q ? 16'd0 - mag3_q : mag3_q;
      dat_d  = v4_q ? s4_q : dat_q;
   end

   always_ff @(posedge aclk) begin
      if (aresetn) begin
         acc_q  <= '0;
         p_q    <= '0;
         v1_q   <= 1'b0;
         idx2_q <= '0;
         neg2_q <= 1'b0;
         v2_q   <= 1'b0;
         mag3_q <= '0;
         neg3_q <= 1'b0;
         v3_q   <= 1'b0;
         s4_q   <= '0;
         v4_q   <= 1'b0;
         dat_q  <= '0;
         vo_q   <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         p_q    <= p_d;
         v1_q   <= accept;
         idx2_q <= idx2_d;
         neg2_q <= p_q[9];
         v2_q   <= v1_q;
         mag3_q <= mag3_d;
         neg3_q <= neg2_q;
         v3_q   <= v2_q;
         s4_q   <= s4_d;
         v4_q   <= v3_q;
         dat_q  <= dat_d;
         vo_q   <= v4_q;
      end
   end

   assign m_axis_data_tvalid = vo_q;
   assign m_axis_data_tdata  = dat_q;

endmodule

// File: tb/tb_dds_compiler.sv
// Directed bench for dds_compiler: hand values plus a floating-point sine
// reference with a four-edge latency model of the output stream.
module tb_dds_compiler;

   localparam real PI = 3.14159265358979323846;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        s_axis_phase_tvalid;
   logic [15:0] s_axis_phase_tdata;
   logic        m_axis_data_tvalid;
   logic [15:0] m_axis_data_tdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] macc;
   logic        pv [5];
   logic [15:0] pd [5];
   logic        ev;
   logic [15:0] ed;

   dds_compiler dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .s_axis_phase_tvalid (s_axis_phase_tvalid),
      .s_axis_phase_tdata  (s_axis_phase_tdata),
      .m_axis_data_tvalid  (m_axis_data_tvalid),
      .m_axis_data_tdata   (m_axis_data_tdata)
   );

   always #5 aclk = ~aclk;

   function automatic int rom_ref(input int k);
      real r;
      r = 32767.0 * $sin(2.0 * PI * real'(k) / 1024.0);
      return int'($floor(r + 0.5));
   endfunction

   function automatic logic [15:0] sample_ref(input logic [15:0] p);
      int i;
      int m;
      i = int'(p[13:6]);
      m = p[14] ? rom_ref(256 - i) : rom_ref(i);
      if (p[15]) m = -m;
      return 16'(m);
   endfunction

   // One clock: drive inputs, take the edge, advance the expectation model.
   task automatic tick(input logic rst, input logic v, input logic [15:0] d);
      aresetn             = rst;
      s_axis_phase_tvalid = v;
      s_axis_phase_tdata  = d;
      @(posedge aclk);
      #1;
      if (rst) begin
         for (int s = 0; s < 5; s++) begin
            pv[s] = 1'b0;
            pd[s] = 16'd0;
         end
         macc = 16'd0;
         ev   = 1'b0;
         ed   = 16'd0;
      end else begin
         for (int s = 4; s > 0; s--) begin
            pv[s] = pv[s-1];
            pd[s] = pd[s-1];
         end
         pv[0] = v;
         pd[0] = v ? sample_ref(macc) : 16'd0;
         if (v) macc = macc + d;
         ev = pv[4];
         if (pv[4]) ed = pd[4];
      end
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b1, 16'h1234);
      tick(1'b1, 1'b1, 16'h1234);
      n_cmp++;
      if (m_axis_data_tvalid !== 1'b0 || m_axis_data_tdata !== 16'd0) begin
         n_bad++;
         $display("FAIL reset: got v=%0b d=%0d, want v=0 d=0",
                  m_axis_data_tvalid, $signed(m_axis_data_tdata));
      end
   endtask

   task automatic test_quarter();
      logic [15:0] pat [4];
      logic        wv;
      logic [15:0] wd;
      pat[0] = 16'h0000;
      pat[1] = 16'h7FFF;
      pat[2] = 16'h0000;
      pat[3] = 16'h8001;
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 14; c++) begin
         tick(1'b0, 1'b1, 16'd16384);
         wv = (c >= 4);
         wd = (c >= 4) ? pat[(c - 4) % 4] : 16'd0;
         n_cmp++;
         if (m_axis_data_tvalid !== wv || m_axis_data_tdata !== wd) begin
            n_bad++;
            $display("FAIL quarter[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), wv, $signed(wd));
         end
      end
   endtask

   task automatic test_low_freq();
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 84; c++) begin
         tick(1'b0, c < 80, 16'd819);
         n_cmp++;
         if (m_axis_data_tvalid !== ev || m_axis_data_tdata !== ed) begin
            n_bad++;
            $display("FAIL low_freq[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), ev, $signed(ed));
         end
         if (c == 5) begin
            n_cmp++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'd2410) begin
               n_bad++;
               $display("FAIL low_freq_second: got d=%0d, want 2410",
                        $signed(m_axis_data_tdata));
            end
         end
         if (c == 24) begin
            n_cmp++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'd32766) begin
               n_bad++;
               $display("FAIL low_freq_peak: got d=%0d, want 32766",
                        $signed(m_axis_data_tdata));
            end
         end
      end
   endtask

   task automatic test_freq_switch();
      logic [15:0] inc;
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 56; c++) begin
         inc = (c < 20) ? 16'd819 : (c < 36) ? 16'd12288 : 16'd24576;
         tick(1'b0, c < 52, inc);
         n_cmp++;
         if (m_axis_data_tvalid !== ev || m_axis_data_tdata !== ed) begin
            n_bad++;
            $display("FAIL freq_switch[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), ev, $signed(ed));
         end
      end
   endtask

   task automatic test_gap();
      logic in_v;
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 19; c++) begin
         in_v = (c < 6) || (c >= 9 && c < 15);
         tick(1'b0, in_v, 16'd4096);
         n_cmp++;
         if (m_axis_data_tvalid !== ev || m_axis_data_tdata !== ed) begin
            n_bad++;
            $display("FAIL gap[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), ev, $signed(ed));
         end
         if (c >= 10 && c <= 12) begin
            n_cmp++;
            if (m_axis_data_tvalid !== 1'b0 || m_axis_data_tdata !== 16'd30273) begin
               n_bad++;
               $display("FAIL gap_hold[%0d]: got v=%0b d=%0d, want v=0 d=30273", c,
                        m_axis_data_tvalid, $signed(m_axis_data_tdata));
            end
         end
         if (c == 13) begin
            n_cmp++;
            if (m_axis_data_tvalid !== 1'b1 || m_axis_data_tdata !== 16'd23170) begin
               n_bad++;
               $display("FAIL gap_resume: got v=%0b d=%0d, want v=1 d=23170",
                        m_axis_data_tvalid, $signed(m_axis_data_tdata));
            end
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic        wv;
      logic [15:0] wd;
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 6; c++) tick(1'b0, 1'b1, 16'd16384);
      tick(1'b1, 1'b1, 16'd16384);
      n_cmp++;
      if (m_axis_data_tvalid !== 1'b0 || m_axis_data_tdata !== 16'd0) begin
         n_bad++;
         $display("FAIL midreset_flush: got v=%0b d=%0d, want v=0 d=0",
                  m_axis_data_tvalid, $signed(m_axis_data_tdata));
      end
      for (int c = 0; c < 7; c++) begin
         tick(1'b0, 1'b1, 16'd16384);
         wv = (c >= 4);
         wd = (c == 5) ? 16'h7FFF : 16'd0;
         n_cmp++;
         if (m_axis_data_tvalid !== wv || m_axis_data_tdata !== wd) begin
            n_bad++;
            $display("FAIL midreset_restart[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), wv, $signed(wd));
         end
      end
   endtask

   task automatic test_wrap();
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 80; c++) begin
         tick(1'b0, c < 76, 16'hFFFF);
         n_cmp++;
         if (m_axis_data_tvalid !== ev || m_axis_data_tdata !== ed) begin
            n_bad++;
            $display("FAIL wrap[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), ev, $signed(ed));
         end
         if (c == 5 || c == 6) begin
            n_cmp++;
            if (m_axis_data_tdata !== 16'hFF37) begin
               n_bad++;
               $display("FAIL wrap_small[%0d]: got d=%0d, want -201", c,
                        $signed(m_axis_data_tdata));
            end
         end
      end
   endtask

   task automatic test_rom_dump();
      tick(1'b1, 1'b0, 16'd0);
      for (int c = 0; c < 1028; c++) begin
         tick(1'b0, c < 1024, 16'd64);
         n_cmp++;
         if (m_axis_data_tvalid !== ev || m_axis_data_tdata !== ed) begin
            n_bad++;
            $display("FAIL rom_dump[%0d]: got v=%0b d=%0d, want v=%0b d=%0d", c,
                     m_axis_data_tvalid, $signed(m_axis_data_tdata), ev, $signed(ed));
         end
      end
   endtask

   initial begin
      aresetn             = 1'b1;
      s_axis_phase_tvalid = 1'b0;
      s_axis_phase_tdata  = 16'd0;
      test_reset();
      test_quarter();
      test_low_freq();
      test_freq_switch();
      test_gap();
      test_reset_midstream();
      test_wrap();
      test_rom_dump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
